// File: rtl/huff_freq_counter_if.sv
// Symbol stream in, frequency-table words out, plus status flags.
// The slave side is the counter; the master side is the message source / encoder loader.
interface huff_freq_counter_if #(
  parameter int CHAR_W = 8,
  parameter int FREQ_W = 3
);
  logic                       sym_valid;
  logic [CHAR_W-1:0]          sym_data;
  logic                       sym_last;
  logic                       sym_ready;
  logic [FREQ_W+CHAR_W:0]     out_word;
  logic                       done;
  logic                       overflow;
  logic                       sat;

  modport master (
    output sym_valid, sym_data, sym_last,
    input  sym_ready, out_word, done, overflow, sat
  );

  modport slave (
    input  sym_valid, sym_data, sym_last,
    output sym_ready, out_word, done, overflow, sat
  );
endinterface

// File: rtl/huff_freq_counter.sv
// Builds a {char, count} table from one message, then streams {1, freq, char} per slot
// back-to-back for the Huffman encoder's load port. One message per reset.
module huff_freq_counter #(
  parameter int MAX_CHAR_COUNT = 3,
  parameter int FREQ_W         = 3,
  parameter int CHAR_W         = 8
) (
  input  logic clk,
  input  logic reset,
  huff_freq_counter_if.slave bus
);
  localparam int IDX_W  = (MAX_CHAR_COUNT > 1) ? $clog2(MAX_CHAR_COUNT) : 1;
  localparam int WORD_W = 1 + FREQ_W + CHAR_W;
  localparam logic [FREQ_W-1:0] FREQ_MAX = '1;

  typedef enum logic [1:0] {COLLECT, EMIT, DONE} state_t;

  state_t                     state_reg, state_next;
  logic [IDX_W-1:0]           idx_reg, idx_next;
  logic [WORD_W-1:0]          out_word_reg, out_word_next;
  logic                       done_reg, done_next;
  logic                       overflow_reg, overflow_next;
  logic                       sat_reg, sat_next;
  logic                       sym_ready_reg, sym_ready_next;
  logic [MAX_CHAR_COUNT-1:0]  occ_reg, occ_next;
  logic [FREQ_W-1:0]          freq_reg [MAX_CHAR_COUNT];
  logic [FREQ_W-1:0]          freq_next[MAX_CHAR_COUNT];
  logic [CHAR_W-1:0]          chr_reg  [MAX_CHAR_COUNT];
  logic [CHAR_W-1:0]          chr_next [MAX_CHAR_COUNT];

  logic [MAX_CHAR_COUNT-1:0]  hit;
  logic                       free_any;
  logic [IDX_W-1:0]           free_idx;
  logic                       accept;

  assign accept = bus.sym_valid && sym_ready_reg;

  // Parallel compare against every occupied slot; the table registers already
  // hold the previous symbol's update, so back-to-back repeats hit correctly.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_CHAR_COUNT; gi++) begin : g_hit
      assign hit[gi] = occ_reg[gi] && (chr_reg[gi] == bus.sym_data);
    end
  endgenerate

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = MAX_CHAR_COUNT - 1; i >= 0; i--) begin
      if (!occ_reg[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    out_word_next = out_word_reg;
    done_next     = done_reg;
    overflow_next = overflow_reg;
    sat_next      = sat_reg;
    occ_next      = occ_reg;
    freq_next     = freq_reg;
    chr_next      = chr_reg;

    case (state_reg)
      COLLECT: begin
        out_word_next = '0;
        if (accept) begin
          if (|hit) begin
            for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
              if (hit[i]) begin
                if (freq_reg[i] == FREQ_MAX) sat_next = 1'b1;
                else                         freq_next[i] = freq_reg[i] + FREQ_W'(1);
              end
            end
          end else if (free_any) begin
            occ_next[free_idx]  = 1'b1;
            freq_next[free_idx] = FREQ_W'(1);
            chr_next[free_idx]  = bus.sym_data;
          end else begin
            overflow_next = 1'b1;
          end
          if (bus.sym_last) begin
            state_next = EMIT;
            idx_next   = '0;
          end
        end
      end
      EMIT: begin
        // Free slots were cleared at reset, so they naturally emit as 0x800 padding.
        out_word_next = {1'b1, freq_reg[idx_reg], chr_reg[idx_reg]};
        if (idx_reg == IDX_W'(MAX_CHAR_COUNT - 1)) state_next = DONE;
        else                                       idx_next   = idx_reg + IDX_W'(1);
      end
      DONE: begin
        out_word_next = '0;
        done_next     = 1'b1;
      end
      default: state_next = COLLECT;
    endcase

    sym_ready_next = (state_next == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= COLLECT;
      idx_reg       <= '0;
      out_word_reg  <= '0;
      done_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      sat_reg       <= 1'b0;
      sym_ready_reg <= 1'b0;
      occ_reg       <= '0;
      for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
        freq_reg[i] <= '0;
        chr_reg[i]  <= '0;
      end
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      out_word_reg  <= out_word_next;
      done_reg      <= done_next;
      overflow_reg  <= overflow_next;
      sat_reg       <= sat_next;
      sym_ready_reg <= sym_ready_next;
      occ_reg       <= occ_next;
      freq_reg      <= freq_next;
      chr_reg       <= chr_next;
    end
  end

  assign bus.sym_ready = sym_ready_reg;
  assign bus.out_word  = out_word_reg;
  assign bus.done      = done_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.sat       = sat_reg;
endmodule

// File: tb/tb_huff_freq_counter.sv
// Directed bench: message table with hand-computed frequency words, plus
// sequences for reset values, EMIT/DONE input blocking and reset mid-EMIT.
module tb_huff_freq_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  huff_freq_counter_if #(.CHAR_W(8), .FREQ_W(3)) bus ();

  huff_freq_counter #(.MAX_CHAR_COUNT(3), .FREQ_W(3), .CHAR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       msg;
    logic [11:0] w0;
    logic [11:0] w1;
    logic [11:0] w2;
    logic        ovf;
    logic        sat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.sym_valid = 1'b0;
    bus.sym_last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns #1 after the edge that accepted the last symbol.
  task automatic send_msg(input string msg, input bit hold);
    for (int i = 0; i < msg.len(); i++) begin
      @(negedge clk);
      bus.sym_valid = 1'b1;
      bus.sym_data  = msg[i];
      bus.sym_last  = (i == msg.len() - 1);
      chk("sym_ready", 32'(bus.sym_ready), 32'd1);
      @(posedge clk);
    end
    #1;
    if (!hold) begin
      bus.sym_valid = 1'b0;
      bus.sym_last  = 1'b0;
    end
  endtask

  task automatic check_emit(input string tag, input logic [11:0] w0, input logic [11:0] w1,
                            input logic [11:0] w2);
    logic [11:0] exp_w [3];
    logic [11:0] got_w [3];
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      got_w[k] = bus.out_word;
      chk({tag, "_word"}, 32'(bus.out_word), 32'(exp_w[k]));
      chk({tag, "_done_low"}, 32'(bus.done), 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_end_word"}, 32'(bus.out_word), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    $display("msg %s: words %h %h %h ovf=%0b sat=%0b", tag, got_w[0], got_w[1], got_w[2],
             bus.overflow, bus.sat);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] hold_exp [4];

    bus.sym_valid = 1'b0;
    bus.sym_data  = 8'h00;
    bus.sym_last  = 1'b0;

    vecs[0] = '{"~|}~|}~|}~|}~|}~|}~}", 12'hF7E, 12'hE7C, 12'hF7D, 1'b0, 1'b0};
    vecs[1] = '{"aaaaaaaaa",            12'hF61, 12'h800, 12'h800, 1'b0, 1'b1};
    vecs[2] = '{"abcd",                 12'h961, 12'h962, 12'h963, 1'b1, 1'b0};
    vecs[3] = '{"aaba",                 12'hB61, 12'h962, 12'h800, 1'b0, 1'b0};
    vecs[4] = '{"abab",                 12'hA61, 12'hA62, 12'h800, 1'b0, 1'b0};

    // Reset values, then ready from the first edge after release
    @(posedge clk); #1;
    chk("rst_word", 32'(bus.out_word), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_sat", 32'(bus.sat), 32'd0);
    chk("rst_ready", 32'(bus.sym_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(bus.sym_ready), 32'd1);
    $display("reset: ready=%0b", bus.sym_ready);

    foreach (vecs[v]) begin
      do_reset();
      send_msg(vecs[v].msg, 1'b0);
      check_emit(vecs[v].msg, vecs[v].w0, vecs[v].w1, vecs[v].w2);
      chk("ovf", 32'(bus.overflow), 32'(vecs[v].ovf));
      chk("sat", 32'(bus.sat), 32'(vecs[v].sat));
    end

    // sym_last without sym_valid is ignored; then 'a' with inputs held active in EMIT/DONE
    do_reset();
    @(negedge clk);
    bus.sym_valid = 1'b0;
    bus.sym_data  = "z";
    bus.sym_last  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("last_no_valid_ready", 32'(bus.sym_ready), 32'd1);
    send_msg("a", 1'b1);
    bus.sym_data = "b";
    hold_exp[0] = 12'h961; hold_exp[1] = 12'h800; hold_exp[2] = 12'h800; hold_exp[3] = 12'h000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("hold_word", 32'(bus.out_word), 32'(hold_exp[k]));
      chk("hold_ready", 32'(bus.sym_ready), 32'd0);
      chk("hold_done", 32'(bus.done), (k == 3) ? 32'd1 : 32'd0);
    end
    repeat (2) begin
      @(posedge clk); #1;
      chk("done_sticky", 32'(bus.done), 32'd1);
      chk("done_word", 32'(bus.out_word), 32'd0);
    end
    bus.sym_valid = 1'b0;
    bus.sym_last  = 1'b0;
    $display("msg a (held valid): done=%0b ready=%0b", bus.done, bus.sym_ready);

    // Reset during the second EMIT cycle clears everything; next message starts clean
    do_reset();
    send_msg("aaaaaaaaabcd", 1'b0);
    @(posedge clk); #1;
    chk("midemit_slot0", 32'(bus.out_word), 32'hF61);
    chk("midemit_ovf_set", 32'(bus.overflow), 32'd1);
    chk("midemit_sat_set", 32'(bus.sat), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midemit_rst_word", 32'(bus.out_word), 32'd0);
    chk("midemit_rst_done", 32'(bus.done), 32'd0);
    chk("midemit_rst_ovf", 32'(bus.overflow), 32'd0);
    chk("midemit_rst_sat", 32'(bus.sat), 32'd0);
    $display("reset mid-EMIT: word=%h ovf=%0b sat=%0b", bus.out_word, bus.overflow, bus.sat);
    @(negedge clk);
    reset = 1'b0;
    send_msg("bb", 1'b0);
    check_emit("bb", 12'hA62, 12'h800, 12'h800);
    chk("bb_ovf", 32'(bus.overflow), 32'd0);
    chk("bb_sat", 32'(bus.sat), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/huff_freq_counter.md
# huff_freq_counter

Upstream front-end of the Huffman encoder. Accepts a raw byte-stream message, builds a table of distinct characters and their occurrence counts, then emits one `{valid, freq, char}` word per table slot on consecutive cycles. The encoder loads these words through its 12-bit `io_in` port. The block turns "a message" into the frequency table the encoder needs, so the encoder never sees raw text.

## Interface
- `MAX_CHAR_COUNT`, 3: number of table slots; must equal the encoder's `MAX_CHAR_COUNT`.
- `FREQ_W`, 3: frequency field width; counts saturate at 2^FREQ_W-1.
- `CHAR_W`, 8: character width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `sym_valid`  in  1  `sym_data` is presented this cycle.
- `sym_data`  in  CHAR_W  message character.
- `sym_last`  in  1  qualifies `sym_valid`; marks the final character of the message.
- `sym_ready`  out  1  block accepts a symbol this cycle.
- `out_word`  out  1+FREQ_W+CHAR_W (12)  `{valid, freq, char}`; connects directly to the encoder's `io_in`.
- `done`  out  1  all words emitted; sticky until reset.
- `overflow`  out  1  sticky; a new distinct character arrived while the table was full.
- `sat`  out  1  sticky; some count hit saturation and further occurrences were dropped.

## Operation
- State machine: COLLECT -> EMIT -> DONE. Reset forces COLLECT from any state.
- COLLECT:
  - `sym_ready`=1.
  - On accept (`sym_valid`&&`sym_ready`), `sym_data` is compared against all occupied slots in parallel.
  - Hit: that slot's freq += 1. If freq is already max, it stays at max and `sat` is set.
  - Miss with a free slot: allocate the lowest free slot, char=`sym_data`, freq=1. Slots fill in first-appearance order.
  - Miss with the table full: symbol dropped; `overflow` set.
  - If `sym_last` is accepted, that symbol is counted, then the FSM moves to EMIT.
- EMIT:
  - `sym_ready`=0; `sym_valid` is ignored.
  - A slot index k runs 0..MAX_CHAR_COUNT-1, one per cycle. `out_word`={1'b1, freq[k], char[k]}.
  - Unoccupied slots are emitted as padding {1'b1, 0, 0}, i.e. 0x800.
  - After the last slot, go to DONE.
- DONE:
  - `out_word`=0, `done`=1, `sym_ready`=0.
  - Held until reset. One message per reset, matching the encoder's load-after-reset protocol.
- Reset values: `out_word`=0, `done`=0, `overflow`=0, `sat`=0, `sym_ready`=0 in the reset cycle, all slots cleared (occupied=0, freq=0, char=0).
- Counts are unsigned FREQ_W-bit values. No wrap-around is permitted.

## Timing
- All outputs are registered; `sym_ready` is decoded from state only.
- `sym_ready`=1 from the first cycle after reset deasserts.
- Throughput in COLLECT: one symbol per cycle. A same-cycle repeat of a just-allocated character must hit the updated table. Lookup uses the next-state table, or an equivalent bypass.
- Emit latency: `sym_last` accepted at edge t gives `out_word` slot 0 valid after edge t+1 and slot k after edge t+1+k.
- `done`=1 and `out_word`=0 after edge t+1+MAX_CHAR_COUNT.
- Words are emitted back-to-back with no gaps and no backpressure; the encoder samples one per cycle.
- Reset mid-COLLECT or mid-EMIT: next cycle is COLLECT with the table cleared, `out_word`=0 and flags cleared. No partial emission resumes.
- `sym_last` with `sym_valid`=0 has no effect.

## Test plan
- Seven '~', six '|', seven '}' interleaved, last on a final '}' -> `out_word` sequence 0xF7E, 0xE7C, 0xF7D on three consecutive cycles, then 0x000 with `done`=1. `overflow`=0, `sat`=0.
- Nine 'a' (0x61), last on the ninth -> 0xF61, 0x800, 0x800. `sat`=1.
- 'a','b','c','d'(last) -> 0x961, 0x962, 0x963. `overflow`=1. The 'd' is absent from the output.
- Single 'a' with `sym_last` -> 0x961, 0x800, 0x800. `done` follows 4 cycles after the accepting edge. `sym_valid` held high during EMIT/DONE changes nothing and `sym_ready` stays 0.
- Same-cycle reuse: 'a','a','b','a'(last), one per cycle with no gaps -> 0xB61 (freq 3), 0x962.
- Reset asserted at the second EMIT cycle -> `out_word`=0 and flags 0 on the next cycle. A subsequent message "bb"(last) -> 0xA62, 0x800, 0x800.
